// File: rtl/serial_sub_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_ctrl_if
// Description : Request/result bundle between a requesting datapath (master)
//               and the bit-serial subtraction controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bor_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bor_out;

    modport master (
        output start, clr, a, b, bor_in,
        input  ready, busy, done, diff, bor_out
    );

    modport slave (
        input  start, clr, a, b, bor_in,
        output ready, busy, done, diff, bor_out
    );
endinterface
`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_ctrl
// Description : Bit-serial subtractor controller. Steps one full-subtractor
//               cell over WIDTH cycles, LSB first, computing a - b - bor_in.
//               start/ready/done handshake, synchronous clr abort.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_sub_ctrl_if.slave   bus
);

    localparam int              CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] sa_q,      sa_d;
    logic [WIDTH-1:0] sb_q,      sb_d;
    logic [WIDTH-1:0] res_q,     res_d;
    logic             br_q,      br_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] diff_q,    diff_d;
    logic             bor_out_q, bor_out_d;

    // Single full-subtractor cell working on the current LSBs
    logic             w_a0;
    logic             w_b0;
    logic             w_bit;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_shift;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clr overrides everything, including a new start
    always_comb begin
        state_d = state_q;
        if (bus.clr) begin
            state_d = C_IDLE;
        end else begin
            case (state_q)
                C_IDLE:  if (bus.start) state_d = C_RUN;
                C_RUN:   if (cnt_q == C_CNT_LAST) state_d = C_DONE;
                C_DONE:  state_d = C_IDLE;
                default: state_d = C_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded purely from the registered state
    always_comb begin
        bus.ready = (state_q == C_IDLE);
        bus.busy  = (state_q == C_RUN);
        bus.done  = (state_q == C_DONE);
    end

    assign bus.diff    = diff_q;
    assign bus.bor_out = bor_out_q;

    // Bit-step cell and result-shift preview (shift right, new bit at MSB)
    always_comb begin
        w_a0        = sa_q[0];
        w_b0        = sb_q[0];
        w_bit       = w_a0 ^ w_b0 ^ br_q;
        w_br_next   = (~w_a0 & w_b0) | (~w_a0 & br_q) | (w_b0 & br_q);
        w_res_shift = res_q >> 1;
        w_res_shift[WIDTH-1] = w_bit;
    end

    // Datapath next values: load on accept, step in RUN, publish on last step
    always_comb begin
        sa_d      = sa_q;
        sb_d      = sb_q;
        res_d     = res_q;
        br_d      = br_q;
        cnt_d     = cnt_q;
        diff_d    = diff_q;
        bor_out_d = bor_out_q;
        if (!bus.clr) begin
            case (state_q)
                C_IDLE: begin
                    if (bus.start) begin
                        sa_d  = bus.a;
                        sb_d  = bus.b;
                        br_d  = bus.bor_in;
                        cnt_d = '0;
                    end
                end
                C_RUN: begin
                    sa_d  = sa_q >> 1;
                    sb_d  = sb_q >> 1;
                    res_d = w_res_shift;
                    br_d  = w_br_next;
                    cnt_d = cnt_q + C_CNT_ONE;
                    if (cnt_q == C_CNT_LAST) begin
                        diff_d    = w_res_shift;
                        bor_out_d = w_br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q      <= '0;
            sb_q      <= '0;
            res_q     <= '0;
            br_q      <= 1'b0;
            cnt_q     <= '0;
            diff_q    <= '0;
            bor_out_q <= 1'b0;
        end else begin
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            res_q     <= res_d;
            br_q      <= br_d;
            cnt_q     <= cnt_d;
            diff_q    <= diff_d;
            bor_out_q <= bor_out_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub_ctrl
// Description : Directed and reference-model bench for serial_sub_ctrl,
//               WIDTH=8 and WIDTH=1 instances side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub_ctrl;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    serial_sub_ctrl_if #(.WIDTH(8)) if8 ();
    serial_sub_ctrl_if #(.WIDTH(1)) if1 ();

    serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (n_cmp=%0d)", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation from IDLE; checks latency, result, done width
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input string tag);
        int         lat;
        logic [8:0] exp;
        logic [7:0] prev;
        exp  = {1'b0, a} - {1'b0, b} - {8'b0, bi};
        prev = if8.diff;
        if8.start  = 1'b1;
        if8.a      = a;
        if8.b      = b;
        if8.bor_in = bi;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if8.start = 1'b0;
            if (!if8.done) check($sformatf("%s_hold", tag), 32'(if8.diff), 32'(prev));
        end while (!if8.done && lat < 40);
        check($sformatf("%s_lat", tag), 32'(lat), 32'd9);
        check($sformatf("%s_diff", tag), 32'(if8.diff), 32'(exp[7:0]));
        check($sformatf("%s_bor", tag), 32'(if8.bor_out), 32'(exp[8]));
        @(posedge clk); #1;
        check($sformatf("%s_donew", tag), 32'(if8.done), 32'd0);
        check($sformatf("%s_rdy", tag), 32'(if8.ready), 32'd1);
    endtask

    // One WIDTH=1 operation from IDLE
    task automatic op1(input logic a, input logic b, input logic bi, input string tag);
        int         lat;
        logic [1:0] exp;
        exp = {1'b0, a} - {1'b0, b} - {1'b0, bi};
        if1.start  = 1'b1;
        if1.a      = a;
        if1.b      = b;
        if1.bor_in = bi;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if1.start = 1'b0;
        end while (!if1.done && lat < 10);
        check($sformatf("%s_lat", tag), 32'(lat), 32'd2);
        check($sformatf("%s_diff", tag), 32'(if1.diff), 32'(exp[0]));
        check($sformatf("%s_bor", tag), 32'(if1.bor_out), 32'(exp[1]));
        @(posedge clk); #1;
        check($sformatf("%s_donew", tag), 32'(if1.done), 32'd0);
    endtask

    initial begin
        int         n;
        int         dcnt;
        logic       rdy_seen;
        logic [7:0] pd;
        logic       pb;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        {if8.start, if8.clr, if8.a, if8.b, if8.bor_in} = '0;
        {if1.start, if1.clr, if1.a, if1.b, if1.bor_in} = '0;

        // Reset state
        #12;
        check("rst_ready", 32'(if8.ready), 32'd1);
        check("rst_busy", 32'(if8.busy), 32'd0);
        check("rst_done", 32'(if8.done), 32'd0);
        check("rst_diff", 32'(if8.diff), 32'd0);
        check("rst_bor", 32'(if8.bor_out), 32'd0);
        check("rst_ready1", 32'(if1.ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        op8(8'h05, 8'h03, 1'b0, "d_5m3");
        check("d_5m3_val", 32'(if8.diff), 32'h02);
        op8(8'h03, 8'h05, 1'b0, "d_3m5");
        check("d_3m5_val", 32'(if8.diff), 32'hFE);
        op8(8'h00, 8'h00, 1'b1, "d_0m0b");
        check("d_0m0b_val", 32'({if8.bor_out, if8.diff}), 32'h1FF);
        op8(8'hFF, 8'h00, 1'b0, "d_ffm0");
        op8(8'h80, 8'h80, 1'b1, "d_80m80b");
        op8(8'hA5, 8'h5A, 1'b1, "d_a5m5a");

        // start held through RUN/DONE with new operands
        if8.start = 1'b1; if8.a = 8'h05; if8.b = 8'h03; if8.bor_in = 1'b0;
        @(posedge clk); #1;
        if8.a = 8'h10; if8.b = 8'h01; if8.bor_in = 1'b1;
        n = 1;
        while (!if8.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("held_lat1", 32'(n), 32'd9);
        check("held_diff1", 32'(if8.diff), 32'h02);
        check("held_bor1", 32'(if8.bor_out), 32'd0);
        n = 0;
        rdy_seen = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) rdy_seen = if8.ready;
        end while (!if8.done && n < 40);
        if8.start = 1'b0;
        check("held_idle", 32'(rdy_seen), 32'd1);
        check("held_lat2", 32'(n), 32'd10);
        check("held_diff2", 32'(if8.diff), 32'h0E);
        check("held_bor2", 32'(if8.bor_out), 32'd0);
        @(posedge clk); #1;

        // clr at the 4th RUN edge
        op8(8'h03, 8'h05, 1'b0, "pre_clr");
        pd = if8.diff;
        pb = if8.bor_out;
        if8.start = 1'b1; if8.a = 8'h05; if8.b = 8'h03; if8.bor_in = 1'b0;
        @(posedge clk); #1;
        if8.start = 1'b0;
        check("clr_busy", 32'(if8.busy), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if8.clr = 1'b1;
        @(posedge clk); #1;
        if8.clr = 1'b0;
        check("clr_ready", 32'(if8.ready), 32'd1);
        check("clr_busy0", 32'(if8.busy), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (if8.done) dcnt++;
        end
        check("clr_nodone", 32'(dcnt), 32'd0);
        check("clr_diff", 32'(if8.diff), 32'(pd));
        check("clr_bor", 32'(if8.bor_out), 32'(pb));

        // Asynchronous reset mid-RUN
        if8.start = 1'b1; if8.a = 8'h05; if8.b = 8'h03; if8.bor_in = 1'b0;
        @(posedge clk); #1;
        if8.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(if8.ready), 32'd1);
        check("arst_busy", 32'(if8.busy), 32'd0);
        check("arst_done", 32'(if8.done), 32'd0);
        check("arst_diff", 32'(if8.diff), 32'd0);
        check("arst_bor", 32'(if8.bor_out), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_rdy_rel", 32'(if8.ready), 32'd1);
        op8(8'h05, 8'h03, 1'b0, "post_rst");

        // WIDTH=1 exhaustive, twice
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 8; v++) begin
                logic [2:0] vv;
                vv = 3'(v);
                op1(vv[2], vv[1], vv[0], $sformatf("w1_%0d", v));
            end
        end

        // Reference-model sweep, WIDTH=8
        for (int k = 0; k < 1000; k++) begin
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
